// File: rtl/sa_pkg.sv
// Shared constants, state encoding and lane-vector type for the 8x8 systolic tile sequencer.
package sa_pkg;

  localparam int N         = 8;            // tile dimension (rows = columns)
  localparam int DW        = 8;            // operand width per lane
  localparam int K_MAX     = 8;            // maximum accumulation depth
  localparam int KW        = 4;            // width of k_len / k_cnt
  localparam int ACC_W     = 19;           // tile accumulator width: 8 x 255 x 255 fits
  localparam int DRAIN_CYC = 2 * (N - 1);  // zero-injection cycles after the last accept

  // Last drain_cnt value before moving to DONE.
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  // One DW-bit operand per lane; lane i occupies bits [i*DW +: DW].
  typedef logic [N-1:0][DW-1:0] lane_vec_t;

  // Requested depths beyond K_MAX are clamped so the accumulators cannot overflow.
  function automatic logic [KW-1:0] clamp_k(input logic [KW-1:0] k);
    return (k > KW'(K_MAX)) ? KW'(K_MAX) : k;
  endfunction

endpackage

// File: rtl/sa_skew_line.sv
// Enable-gated delay line producing the diagonal skew for one tile edge lane.
// DEPTH=0 degenerates to a plain wire.
module sa_skew_line
  import sa_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  if (DEPTH == 0) begin : g_wire

    // Control inputs have no effect on a zero-depth lane.
    logic unused_ctrl;
    assign unused_ctrl = ^{CLK, RST, clr, en};
    assign dout        = din;

  end else begin : g_shift

    logic [DEPTH-1:0][DW-1:0] stage_q, stage_d;

    // Next stage contents: clear, shift by one when enabled, otherwise hold.
    always_comb begin
      // NOTE: assigning the hold value first keeps this always_comb free of inferred latches.
      stage_d = stage_q;
      if (clr) begin
        stage_d = '0;
      end else if (en) begin
        stage_d[0] = din;
        for (int s = 1; s < DEPTH; s++) begin
          stage_d[s] = stage_q[s-1];
        end
      end
    end

    // Stage register with synchronous reset.
    always_ff @(posedge CLK) begin
      // NOTE: every stage is reset so the tile edge reads zero after an aborted job, not stale operands.
      if (RST) begin
        stage_q <= '0;
      end else begin
        // NOTE: non-blocking assignment so every stage samples its neighbour's pre-edge value.
        stage_q <= stage_d;
      end
    end

    assign dout = stage_q[DEPTH-1];

  end

endmodule

// File: rtl/sa_tile_seq.sv
// Sequencer for one 8x8 output-stationary systolic tile: clears the accumulators,
// feeds K skewed operand pairs, drains with zeros and flags the final results.
module sa_tile_seq
  import sa_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  output logic            busy,
  output logic            done,
  output logic            res_valid,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [N*DW-1:0] op_a,
  input  logic [N*DW-1:0] op_b,
  output logic            tile_rst,
  output logic            tile_en,
  output logic [N*DW-1:0] tile_row,
  output logic [N*DW-1:0] tile_col
);

  state_t          state_q, state_d;
  logic [KW-1:0]   klen_q, klen_d;
  logic [KW-1:0]   k_cnt_q, k_cnt_d;
  logic [3:0]      drain_cnt_q, drain_cnt_d;
  logic            res_valid_q, res_valid_d;

  logic            accept;
  logic            skew_clr;
  lane_vec_t       a_lanes, b_lanes;
  lane_vec_t       a_din, b_din;
  lane_vec_t       row_out, col_out;

  assign a_lanes = op_a;
  assign b_lanes = op_b;

  // Handshake, tile controls and skew inputs decoded from the current state.
  always_comb begin
    op_ready  = (state_q == FEED) && !RST;
    accept    = op_ready && op_valid;
    // The array only steps on an accept while feeding, so an empty input stalls every PE together.
    tile_en   = !RST && (accept || (state_q == DRAIN));
    tile_rst  = RST || (state_q == CLEAR);
    skew_clr  = (state_q == CLEAR);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE) && !RST;
    res_valid = res_valid_q;
    // Operands enter only while feeding; the drain pushes zeros behind the last product.
    a_din     = (state_q == FEED) ? a_lanes : '0;
    b_din     = (state_q == FEED) ? b_lanes : '0;
  end

  // Next-state and counter updates.
  always_comb begin
    state_d     = state_q;
    klen_d      = klen_q;
    k_cnt_d     = k_cnt_q;
    drain_cnt_d = drain_cnt_q;
    res_valid_d = res_valid_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          klen_d      = clamp_k(k_len);
          k_cnt_d     = '0;
          res_valid_d = 1'b0;
          state_d     = CLEAR;
        end
      end
      CLEAR: begin
        k_cnt_d     = '0;
        drain_cnt_d = '0;
        if (klen_q == '0) begin
          // Nothing to accumulate: the cleared tile already holds the all-zero result.
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = FEED;
        end
      end
      FEED: begin
        if (accept) begin
          k_cnt_d = k_cnt_q + 1'b1;
          if (k_cnt_q == klen_q - 1'b1) begin
            drain_cnt_d = '0;
            state_d     = DRAIN;
          end
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + 4'd1;
        if (drain_cnt_q == DRAIN_LAST) begin
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      klen_q      <= '0;
      k_cnt_q     <= '0;
      drain_cnt_q <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      klen_q      <= klen_d;
      k_cnt_q     <= k_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Row lane i and column lane j are delayed by i and j enabled steps respectively.
  for (genvar i = 0; i < N; i++) begin : g_lane
    sa_skew_line #(.DEPTH(i)) u_row_skew (
      .CLK  (CLK),
      .RST  (RST),
      .clr  (skew_clr),
      .en   (tile_en),
      .din  (a_din[i]),
      .dout (row_out[i])
    );
    sa_skew_line #(.DEPTH(i)) u_col_skew (
      .CLK  (CLK),
      .RST  (RST),
      .clr  (skew_clr),
      .en   (tile_en),
      .din  (b_din[i]),
      .dout (col_out[i])
    );
  end

  assign tile_row = row_out;
  assign tile_col = col_out;

endmodule
